cp0_int_ctrl: RTL and testbench

- Coprocessor-0 interrupt controller sitting directly downstream of the bus devices (timer0, timer1, external interrupt line).
- Gathers their IRQ lines into HWInt[7:2], masks them against SR and raises IntReq to the pipeline controller.
- On interrupt entry it captures EPC and sets EXL; `eret` clears EXL.
- Serves `mfc0`/`mtc0` accesses from the M stage.

---
 rtl/cp0_int_ctrl_if.sv | 28 ++
 rtl/cp0_int_ctrl.sv | 127 ++++++++++++
 tb/tb_cp0_int_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cp0_int_ctrl_if.sv
// Pipeline-side bundle for the CP0 interrupt controller: mfc0/mtc0 access,
// victim-PC capture, device IRQ lines and the interrupt/eret outputs.
interface cp0_int_ctrl_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        BDIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPCOut;
  logic [31:0] HandlerPC;
  logic [31:0] DOut;

  // Pipeline/controller side
  modport master (
    output A1, A2, DIn, We, PC, BDIn, HWInt, EXLClr,
    input  IntReq, EPCOut, HandlerPC, DOut
  );

  // Coprocessor side
  modport slave (
    input  A1, A2, DIn, We, PC, BDIn, HWInt, EXLClr,
    output IntReq, EPCOut, HandlerPC, DOut
  );
endinterface

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: masks HWInt against SR, raises IntReq, captures
// EPC/BD on entry, clears EXL on eret and serves mfc0/mtc0.
module cp0_int_ctrl #(
  parameter logic [31:0] PRID    = 32'h0000_1801,
  parameter logic [31:0] HANDLER = 32'h0000_4180
) (
  input  logic         clk,
  input  logic         clr,
  cp0_int_ctrl_if.slave bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  // EPC
  logic [31:0] r_epc;

  logic [5:0]  w_im_next;
  logic        w_exl_next;
  logic        w_ie_next;
  logic        w_bd_next;
  logic [5:0]  w_ip_next;
  logic [4:0]  w_exccode_next;
  logic [31:0] w_epc_next;

  logic        w_int_req;
  logic [31:0] w_pc_aligned;
  logic [31:0] w_victim_pc;
  logic [31:0] w_sr_word;
  logic [31:0] w_cause_word;
  logic [31:0] w_dout;
  logic        w_unused;

  assign w_int_req    = (|(bus.HWInt & r_im)) & r_ie & ~r_exl;
  assign w_pc_aligned = {bus.PC[31:2], 2'b00};
  // A delay-slot victim restarts at its branch so the branch re-executes.
  assign w_victim_pc  = bus.BDIn ? (w_pc_aligned - 32'd4) : w_pc_aligned;

  assign w_sr_word    = {16'h0000, r_im, 8'h00, r_exl, r_ie};
  assign w_cause_word = {r_bd, 15'h0000, r_ip, 3'b000, r_exccode, 2'b00};

  always_comb begin
    w_dout = 32'h0000_0000;
    case (bus.A1)
      ADDR_SR:    w_dout = w_sr_word;
      ADDR_CAUSE: w_dout = w_cause_word;
      ADDR_EPC:   w_dout = r_epc;
      ADDR_PRID:  w_dout = PRID;
      default:    w_dout = 32'h0000_0000;
    endcase
  end

  assign bus.IntReq    = w_int_req;
  assign bus.EPCOut    = r_epc;
  assign bus.HandlerPC = HANDLER;
  assign bus.DOut      = w_dout;

  // Next-state: interrupt entry beats eret, which beats a plain mtc0.
  always_comb begin
    w_im_next      = r_im;
    w_exl_next     = r_exl;
    w_ie_next      = r_ie;
    w_bd_next      = r_bd;
    w_ip_next      = bus.HWInt;
    w_exccode_next = r_exccode;
    w_epc_next     = r_epc;

    if (w_int_req) begin
      // The M-stage instruction is flushed, so its mtc0 must not commit.
      w_epc_next     = w_victim_pc;
      w_bd_next      = bus.BDIn;
      w_exccode_next = 5'd0;
      w_exl_next     = 1'b1;
    end else begin
      if (bus.EXLClr) begin
        w_exl_next = 1'b0;
      end
      if (bus.We) begin
        case (bus.A2)
          ADDR_SR: begin
            w_im_next  = bus.DIn[15:10];
            w_exl_next = bus.EXLClr ? 1'b0 : bus.DIn[1];
            w_ie_next  = bus.DIn[0];
          end
          ADDR_EPC: begin
            w_epc_next = {bus.DIn[31:2], 2'b00};
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'h0000_0000;
    end else begin
      r_im      <= w_im_next;
      r_exl     <= w_exl_next;
      r_ie      <= w_ie_next;
      r_bd      <= w_bd_next;
      r_ip      <= w_ip_next;
      r_exccode <= w_exccode_next;
      r_epc     <= w_epc_next;
    end
  end

  assign w_unused = ^{bus.DIn[9:2], bus.PC[1:0]};

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: directed scenarios then random traffic, all checked
// against a word-level model of SR/Cause/EPC.
module tb_cp0_int_ctrl;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  cp0_int_ctrl_if bus ();

  cp0_int_ctrl #(
    .PRID    (32'h0000_1801),
    .HANDLER (32'h0000_4180)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state kept as whole architectural words.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_intreq();
    return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_dout(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_1801;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_update();
    logic ir;
    ir = m_intreq();
    if (clr) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause[15:10] = bus.HWInt;
      if (ir) begin
        m_epc = (bus.PC & 32'hFFFF_FFFC) - (bus.BDIn ? 32'd4 : 32'd0);
        m_cause[31] = bus.BDIn;
        m_cause[6:2] = 5'd0;
        m_sr[1] = 1'b1;
      end else begin
        if (bus.EXLClr) m_sr[1] = 1'b0;
        if (bus.We && bus.A2 == 5'd12) begin
          m_sr = bus.DIn & 32'h0000_FC03;
          if (bus.EXLClr) m_sr[1] = 1'b0;
        end else if (bus.We && bus.A2 == 5'd14) begin
          m_epc = bus.DIn & 32'hFFFF_FFFC;
        end
      end
    end
  endtask

  // Compare outputs mid-low-phase, then let one posedge happen.
  task automatic cycle();
    #1;
    check("intreq", {31'b0, bus.IntReq}, {31'b0, m_intreq()});
    check("dout", bus.DOut, m_dout(bus.A1));
    check("epcout", bus.EPCOut, m_epc);
    check("handler", bus.HandlerPC, 32'h0000_4180);
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle();
    clr = 0; bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 0; bus.We = 0;
    bus.PC = 0; bus.BDIn = 0; bus.HWInt = 0; bus.EXLClr = 0;
  endtask

  task automatic do_reset();
    idle(); clr = 1; cycle(); clr = 0;
  endtask

  task automatic write_sr(input logic [31:0] v);
    idle(); bus.We = 1; bus.A2 = 5'd12; bus.DIn = v; cycle(); idle();
  endtask

  task automatic read_lit(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.A1 = a; #1;
    check(tag, bus.DOut, exp);
  endtask

  task automatic irq_lit(input string tag, input logic exp);
    #1;
    check(tag, {31'b0, bus.IntReq}, {31'b0, exp});
  endtask

  initial begin
    checks = 0; errors = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle(); clr = 1;
    @(posedge clk); m_update(); @(negedge clk);
    clr = 0;

    // Reset readback
    read_lit("rst_sr", 5'd12, 32'h0);
    read_lit("rst_cause", 5'd13, 32'h0);
    read_lit("rst_epc", 5'd14, 32'h0);
    read_lit("rst_prid", 5'd15, 32'h0000_1801);
    irq_lit("rst_irq", 1'b0);
    cycle();

    // Plain interrupt entry
    write_sr(32'h0000_0401);
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_3010;
    irq_lit("entry_irq", 1'b1);
    cycle();
    read_lit("entry_epc", 5'd14, 32'h0000_3010);
    read_lit("entry_sr", 5'd12, 32'h0000_0403);
    read_lit("entry_cause", 5'd13, 32'h0000_0400);
    irq_lit("entry_irq_off", 1'b0);
    cycle();

    // Delay-slot entry
    do_reset();
    write_sr(32'h0000_0401);
    bus.HWInt = 6'b000001; bus.PC = 32'h0000_3024; bus.BDIn = 1;
    cycle();
    bus.BDIn = 0;
    read_lit("bd_epc", 5'd14, 32'h0000_3020);
    read_lit("bd_cause", 5'd13, 32'h8000_0400);
    cycle();

    // Masked line, then entry with a concurrent mtc0 EPC
    do_reset();
    write_sr(32'h0000_0801);
    bus.HWInt = 6'b000001;
    irq_lit("masked_irq", 1'b0);
    cycle();
    bus.HWInt = 6'b000010; bus.PC = 32'h0000_3040;
    bus.We = 1; bus.A2 = 5'd14; bus.DIn = 32'h1234_5678;
    irq_lit("sim_irq", 1'b1);
    cycle();
    bus.We = 0;
    read_lit("sim_epc", 5'd14, 32'h0000_3040);
    cycle();

    // eret with held IRQ re-enters immediately
    bus.EXLClr = 1;
    cycle();
    bus.EXLClr = 0;
    read_lit("eret_sr", 5'd12, 32'h0000_0801);
    irq_lit("eret_reirq", 1'b1);
    cycle();
    // Drop the line before eret: no re-entry
    bus.HWInt = 6'b000000; bus.EXLClr = 1;
    cycle();
    bus.EXLClr = 0;
    irq_lit("eret_quiet", 1'b0);
    cycle();

    // clr mid-handler
    bus.HWInt = 6'b000010; bus.PC = 32'h0000_3100;
    cycle();
    bus.HWInt = 6'b111111; clr = 1;
    cycle();
    clr = 0;
    read_lit("clr_sr", 5'd12, 32'h0);
    read_lit("clr_cause", 5'd13, 32'h0);
    read_lit("clr_epc", 5'd14, 32'h0);
    irq_lit("clr_irq", 1'b0);
    cycle();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      clr         = ($urandom_range(0, 99) == 0);
      bus.A1      = 5'($urandom_range(10, 16));
      bus.We      = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: bus.A2 = 5'd12;
        1: bus.A2 = 5'd14;
        2: bus.A2 = 5'd13;
        default: bus.A2 = 5'($urandom);
      endcase
      bus.DIn     = $urandom;
      bus.PC      = $urandom;
      bus.BDIn    = 1'($urandom);
      bus.HWInt   = 6'($urandom_range(0, 7));
      bus.EXLClr  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
